dxm_demux_sync: RTL and testbench

- Registered 1-to-NUM_OUT stream demultiplexer for the TRNG sample path. It is the distribution end of the source-select mux.
- Routes a valid/ready sample stream to exactly one selected consumer.
- Source switches occur only at a safe boundary: the in-flight sample is drained first, then a programmable number of post-switch samples is discarded so no stale or transient samples reach the new consumer.

---
 rtl/dxm_demux_sync.sv | 199 +++++++++++++++++++
 tb/tb_dxm_demux_sync.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dxm_demux_sync.sv
// dxm_demux_sync: registered 1-to-num_out sample demux that switches channels only after draining
// the held sample and discarding blank_samples inputs. Optional macro DXM_DEMUX_DROP_CNT_EN adds drop_cnt.

// Output invariants: at most one channel valid, and only the active one.
module dxm_demux_sync_chk #(
   parameter int num_out   = 2,
   parameter int sel_width = 1
) (
   input logic                 clk,
   input logic                 rst,
   input logic [num_out-1:0]   out_valid,
   input logic [sel_width-1:0] cur_sel
);
   a_onehot_valid: assert property (@(posedge clk) disable iff (rst) $onehot0(out_valid));
   a_valid_on_cur: assert property (@(posedge clk) disable iff (rst)
                                    (out_valid == {num_out{1'b0}}) || out_valid[cur_sel]);
endmodule

module dxm_demux_sync #(
   parameter int data_width    = 1,
   parameter int num_out       = 2,
   parameter int sel_width     = 1,
   parameter int blank_samples = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [data_width-1:0]         in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [sel_width-1:0]          sel_req,
   input  logic                          sel_load,
   output logic                          sel_busy,
   output logic [sel_width-1:0]          cur_sel,
   output logic [num_out*data_width-1:0] out_data,
   output logic [num_out-1:0]            out_valid,
   input  logic [num_out-1:0]            out_ready
`ifdef DXM_DEMUX_DROP_CNT_EN
   ,
   output logic [15:0]                   drop_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   localparam logic [7:0]         BLANK_INIT = 8'(blank_samples);
   localparam logic [sel_width:0] NUM_OUT_L  = (sel_width+1)'(num_out);

   state_t                state_r, state_s;
   logic [sel_width-1:0]  cur_sel_r, cur_sel_s;
   logic [sel_width-1:0]  pend_sel_r, pend_sel_s;
   logic [7:0]            blank_cnt_r, blank_cnt_s;
   logic [data_width-1:0] hold_data_r, hold_data_s;
   logic [num_out-1:0]    out_valid_r, out_valid_s;
   logic                  hold_vld_s;
   logic                  hold_vld_nxt_s;
   logic                  out_xfer_s;
   logic                  ready_s;
   logic                  sel_ok_s;
   logic                  drop_s;

   function automatic logic [num_out-1:0] chan_onehot(input logic [sel_width-1:0] s);
      chan_onehot = {{(num_out-1){1'b0}}, 1'b1} << s;
   endfunction

   assign hold_vld_s = |out_valid_r;
   assign out_xfer_s = hold_vld_s && out_ready[cur_sel_r];
   assign sel_ok_s   = sel_load && (sel_req != cur_sel_r) && ({1'b0, sel_req} < NUM_OUT_L);

   // Next-state, acceptance and holding-register update.
   always_comb begin
      state_s        = state_r;
      cur_sel_s      = cur_sel_r;
      pend_sel_s     = pend_sel_r;
      blank_cnt_s    = blank_cnt_r;
      hold_data_s    = hold_data_r;
      hold_vld_nxt_s = hold_vld_s;
      ready_s        = 1'b0;
      drop_s         = 1'b0;
      case (state_r)
         ST_RUN: begin
            ready_s = !hold_vld_s || out_ready[cur_sel_r];
            if (sel_ok_s) begin
               state_s    = ST_DRAIN;
               pend_sel_s = sel_req;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            ready_s = 1'b0;
            // The held sample may leave in this very cycle; the switch then completes now.
            if (!hold_vld_s || out_xfer_s) begin
               cur_sel_s = pend_sel_r;
               if (BLANK_INIT != 8'd0) begin
                  state_s     = ST_BLANK;
                  blank_cnt_s = BLANK_INIT;
               end else begin
                  state_s = ST_RUN;
               end
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_BLANK: begin
            ready_s = 1'b1;
            if (in_valid) begin
               drop_s      = 1'b1;
               blank_cnt_s = blank_cnt_r - 8'd1;
               if (blank_cnt_r <= 8'd1) begin
                  state_s = ST_RUN;
               end else begin
                  state_s = ST_BLANK;
               end
            end else begin
               state_s = ST_BLANK;
            end
         end
         default: begin
            state_s = ST_RUN;
            ready_s = 1'b0;
         end
      endcase

      if ((state_r == ST_RUN) && in_valid && ready_s) begin
         hold_vld_nxt_s = 1'b1;
         hold_data_s    = in_data;
      end else if (out_xfer_s) begin
         hold_vld_nxt_s = 1'b0;
      end else begin
         hold_vld_nxt_s = hold_vld_s;
      end

      if (hold_vld_nxt_s) begin
         out_valid_s = chan_onehot(cur_sel_r);
      end else begin
         out_valid_s = {num_out{1'b0}};
      end
   end

   // State, channel select, blank counter and holding register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_RUN;
         cur_sel_r   <= {sel_width{1'b0}};
         pend_sel_r  <= {sel_width{1'b0}};
         blank_cnt_r <= 8'd0;
         hold_data_r <= {data_width{1'b0}};
         out_valid_r <= {num_out{1'b0}};
      end else begin
         state_r     <= state_s;
         cur_sel_r   <= cur_sel_s;
         pend_sel_r  <= pend_sel_s;
         blank_cnt_r <= blank_cnt_s;
         hold_data_r <= hold_data_s;
         out_valid_r <= out_valid_s;
      end
   end

   assign in_ready  = ready_s && !rst;
   assign sel_busy  = (state_r != ST_RUN);
   assign cur_sel   = cur_sel_r;
   assign out_valid = out_valid_r;
   assign out_data  = {num_out{hold_data_r}};

`ifdef DXM_DEMUX_DROP_CNT_EN
   logic [15:0] drop_cnt_r;

   // Saturating count of samples discarded while blanking.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_r <= 16'd0;
      end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
         drop_cnt_r <= drop_cnt_r + 16'd1;
      end else begin
         drop_cnt_r <= drop_cnt_r;
      end
   end

   assign drop_cnt = drop_cnt_r;
`else
   logic drop_unused_s;
   assign drop_unused_s = drop_s;
`endif

   dxm_demux_sync_chk #(
      .num_out   (num_out),
      .sel_width (sel_width)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .out_valid (out_valid_r),
      .cur_sel   (cur_sel_r)
   );

endmodule

// File: tb/tb_dxm_demux_sync.sv
// Self-checking bench for dxm_demux_sync: scoreboard of delivered samples plus per-scenario checks.
module tb_dxm_demux_sync;

   logic        clk;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  sel_req;
   logic        sel_load;
   logic        sel_busy;
   logic [1:0]  cur_sel;
   logic [23:0] out_data;
   logic [2:0]  out_valid;
   logic [2:0]  out_ready;

   logic [7:0]  b_in_data;
   logic        b_in_valid;
   logic        b_in_ready;
   logic        b_sel_req;
   logic        b_sel_load;
   logic        b_sel_busy;
   logic        b_cur_sel;
   logic [15:0] b_out_data;
   logic [1:0]  b_out_valid;
   logic [1:0]  b_out_ready;
`ifdef DXM_DEMUX_DROP_CNT_EN
   logic [15:0] drop_cnt;
   logic [15:0] b_drop_cnt;
`endif

   int errors = 0;
   int checks = 0;
   logic [9:0] exp_q[$];

   dxm_demux_sync #(.data_width(8), .num_out(3), .sel_width(2), .blank_samples(4)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sel_req(sel_req), .sel_load(sel_load), .sel_busy(sel_busy), .cur_sel(cur_sel),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef DXM_DEMUX_DROP_CNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   dxm_demux_sync #(.data_width(8), .num_out(2), .sel_width(1), .blank_samples(0)) dut0 (
      .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .sel_req(b_sel_req), .sel_load(b_sel_load), .sel_busy(b_sel_busy), .cur_sel(b_cur_sel),
      .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready)
`ifdef DXM_DEMUX_DROP_CNT_EN
      , .drop_cnt(b_drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Scoreboard: every output transfer must match the oldest expected {channel, data}.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid != 3'b000) begin
            checks++;
            if (!$onehot(out_valid)) begin
               errors++;
               $display("FAIL out_valid_onehot: got %b, required at most one bit", out_valid);
            end
         end
         for (int c = 0; c < 3; c++) begin
            if (out_valid[c] && out_ready[c]) begin
               logic [9:0] e;
               logic [9:0] got;
               got = {2'(c), out_data[c*8 +: 8]};
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_output: ch=%0d data=%h, required no output", c, out_data[c*8 +: 8]);
               end else begin
                  e = exp_q.pop_front();
                  if (got !== e) begin
                     errors++;
                     $display("FAIL scoreboard: got ch=%0d data=%h, required ch=%0d data=%h",
                              got[9:8], got[7:0], e[9:8], e[7:0]);
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // Offer one sample; push it to the scoreboard if it should be delivered on channel ch.
   task automatic send(input logic [7:0] d, input bit deliver, input logic [1:0] ch, output int waits);
      bit done;
      done     = 1'b0;
      waits    = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (!done && waits <= 50) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            if (deliver) exp_q.push_back({ch, d});
            done = 1'b1;
         end else begin
            waits++;
         end
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL send_timeout: data=%h not accepted, required acceptance within 50 cycles", d);
      end
   endtask

   task automatic check_q_empty(input string tag);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_queue: %0d samples still expected, required 0", tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_ctl(input string tag, input logic busy_e, input logic [1:0] sel_e);
      checks++;
      if (sel_busy !== busy_e || cur_sel !== sel_e) begin
         errors++;
         $display("FAIL %s: busy=%b cur_sel=%0d, required busy=%b cur_sel=%0d", tag, sel_busy, cur_sel, busy_e, sel_e);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, required 0", in_ready);
      end
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_ctl("reset_ctl", 1'b0, 2'd0);
      checks++;
      if (out_valid !== 3'b000 || out_data !== 24'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b data=%h ready=%b, required 000 000000 1", out_valid, out_data, in_ready);
      end
`ifdef DXM_DEMUX_DROP_CNT_EN
      checks++;
      if (drop_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt);
      end
`endif
      tick();
   endtask

   task automatic test_basic();
      int w;
      out_ready = 3'b001;
      send(8'h01, 1'b1, 2'd0, w);
      @(negedge clk);
      checks++;
      if (out_valid !== 3'b001 || out_data !== 24'h010101) begin
         errors++;
         $display("FAIL basic_latency: valid=%b data=%h, required 001 010101", out_valid, out_data);
      end
      tick();
      send(8'h00, 1'b1, 2'd0, w);
      send(8'h01, 1'b1, 2'd0, w);
      idle(2);
      check_q_empty("basic");
   endtask

   task automatic test_back_to_back();
      int w;
      out_ready = 3'b000;
      send(8'hA1, 1'b1, 2'd0, w);
      in_data  = 8'hB2;
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 3'b001 || out_data[7:0] !== 8'hA1) begin
            errors++;
            $display("FAIL backpressure: ready=%b valid=%b data=%h, required 0 001 a1", in_ready, out_valid, out_data[7:0]);
         end
         tick();
      end
      out_ready = 3'b001;
      send(8'hB2, 1'b1, 2'd0, w);
      for (int i = 0; i < 3; i++) begin
         send(8'hC3 + 8'(i), 1'b1, 2'd0, w);
         checks++;
         if (w != 0) begin
            errors++;
            $display("FAIL throughput: waited %0d cycles, required 0", w);
         end
      end
      idle(3);
      check_q_empty("back_to_back");
   endtask

   task automatic test_switch_drain();
      int w;
      out_ready = 3'b000;
      send(8'h77, 1'b1, 2'd0, w);
      sel_req  = 2'd1;
      sel_load = 1'b1;
      tick();
      sel_load = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_ctl("drain_hold", 1'b1, 2'd0);
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_in_ready: got %b, required 0", in_ready);
         end
         tick();
      end
      out_ready = 3'b011;
      @(negedge clk);
      check_ctl("drain_exit_cycle", 1'b1, 2'd0);
      tick();
      @(negedge clk);
      check_ctl("after_drain", 1'b1, 2'd1);
      checks++;
      if (out_valid !== 3'b000 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL blank_entry: valid=%b ready=%b, required 000 1", out_valid, in_ready);
      end
      tick();
      check_q_empty("switch");
   endtask

   task automatic test_blank();
      int w;
      send(8'hA0, 1'b0, 2'd1, w);
      send(8'hB0, 1'b0, 2'd1, w);
      idle(2);
      @(negedge clk);
      check_ctl("blank_hold_no_valid", 1'b1, 2'd1);
      tick();
      sel_req  = 2'd0;
      sel_load = 1'b1;
      tick();
      sel_load = 1'b0;
      @(negedge clk);
      check_ctl("blank_sel_load_ignored", 1'b1, 2'd1);
      tick();
      send(8'hC0, 1'b0, 2'd1, w);
      send(8'hD0, 1'b0, 2'd1, w);
      @(negedge clk);
      check_ctl("blank_done", 1'b0, 2'd1);
      tick();
      send(8'hE0, 1'b1, 2'd1, w);
      send(8'hF0, 1'b1, 2'd1, w);
      idle(2);
      check_q_empty("blank");
`ifdef DXM_DEMUX_DROP_CNT_EN
      checks++;
      if (drop_cnt !== 16'd4) begin
         errors++;
         $display("FAIL drop_cnt: got %0d, required 4", drop_cnt);
      end
`endif
   endtask

   task automatic test_ignored();
      int w;
      sel_req  = 2'd1;
      sel_load = 1'b1;
      tick();
      sel_load = 1'b0;
      @(negedge clk);
      check_ctl("ignore_same_sel", 1'b0, 2'd1);
      tick();
      sel_req  = 2'd3;
      sel_load = 1'b1;
      tick();
      sel_load = 1'b0;
      @(negedge clk);
      check_ctl("ignore_out_of_range", 1'b0, 2'd1);
      tick();
      send(8'h3C, 1'b1, 2'd1, w);
      idle(2);
      check_q_empty("ignored");
   endtask

   task automatic test_reset_abort();
      int w;
      out_ready = 3'b111;
      sel_req   = 2'd2;
      sel_load  = 1'b1;
      tick();
      sel_load = 1'b0;
      tick();
      @(negedge clk);
      check_ctl("abort_in_blank", 1'b1, 2'd2);
      tick();
      send(8'h11, 1'b0, 2'd2, w);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_ctl("abort_reset_ctl", 1'b0, 2'd0);
      checks++;
      if (out_valid !== 3'b000) begin
         errors++;
         $display("FAIL abort_reset_valid: got %b, required 000", out_valid);
      end
`ifdef DXM_DEMUX_DROP_CNT_EN
      checks++;
      if (drop_cnt !== 16'd0) begin
         errors++;
         $display("FAIL abort_drop_cnt: got %0d, required 0", drop_cnt);
      end
`endif
      tick();
      out_ready = 3'b001;
      send(8'h22, 1'b1, 2'd0, w);
      idle(2);
      out_ready = 3'b000;
      send(8'h33, 1'b0, 2'd0, w);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 3'b000 || out_data !== 24'h0) begin
         errors++;
         $display("FAIL reset_discards_held: valid=%b data=%h, required 000 000000", out_valid, out_data);
      end
      tick();
      out_ready = 3'b001;
      idle(3);
      check_q_empty("reset_abort");
   endtask

   task automatic test_no_blank();
      b_out_ready = 2'b11;
      b_sel_req   = 1'b1;
      b_sel_load  = 1'b1;
      tick();
      b_sel_load = 1'b0;
      @(negedge clk);
      checks++;
      if (b_sel_busy !== 1'b1 || b_cur_sel !== 1'b0) begin
         errors++;
         $display("FAIL noblank_drain: busy=%b cur_sel=%b, required 1 0", b_sel_busy, b_cur_sel);
      end
      tick();
      @(negedge clk);
      checks++;
      if (b_sel_busy !== 1'b0 || b_cur_sel !== 1'b1) begin
         errors++;
         $display("FAIL noblank_run: busy=%b cur_sel=%b, required 0 1", b_sel_busy, b_cur_sel);
      end
      tick();
      b_in_data  = 8'h5A;
      b_in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (b_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL noblank_ready: got %b, required 1", b_in_ready);
      end
      tick();
      b_in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (b_out_valid !== 2'b10 || b_out_data[15:8] !== 8'h5A) begin
         errors++;
         $display("FAIL noblank_first: valid=%b data=%h, required 10 5a", b_out_valid, b_out_data[15:8]);
      end
`ifdef DXM_DEMUX_DROP_CNT_EN
      checks++;
      if (b_drop_cnt !== 16'd0) begin
         errors++;
         $display("FAIL noblank_drop_cnt: got %0d, required 0", b_drop_cnt);
      end
`endif
      tick();
   endtask

   initial begin
      rst         = 1'b1;
      in_data     = 8'h00;
      in_valid    = 1'b0;
      sel_req     = 2'd0;
      sel_load    = 1'b0;
      out_ready   = 3'b000;
      b_in_data   = 8'h00;
      b_in_valid  = 1'b0;
      b_sel_req   = 1'b0;
      b_sel_load  = 1'b0;
      b_out_ready = 2'b00;
      test_reset();
      test_basic();
      test_back_to_back();
      test_switch_drain();
      test_blank();
      test_ignored();
      test_reset_abort();
      test_no_blank();
      idle(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
